// File: rtl/iir_cfg_pkg.sv
// Shared types for the IIR coefficient loader.
// Optional bypass-hold behaviour is enabled with IIR_CFG_BYPASS_HOLD_EN.
package iir_cfg_pkg;

  localparam int NUM_COEFF = 5;
  localparam int DEF_COEFF_WIDTH = 20;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coeff_idx_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT,
    CHECK,
    HOLD
  } loader_state_e;

  typedef logic signed [NUM_COEFF-1:0][DEF_COEFF_WIDTH-1:0] coeff_bank_t;

  function automatic logic [31:0] unity_coeff(input int frac);
    return 32'd1 << frac;
  endfunction

endpackage

// File: rtl/iir_coeff_loader_if.sv
// Config-bus handshake between register block and coefficient loader.
// Master drives words and commit; slave returns ready.
interface iir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 20
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_addr;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   cfg_commit;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/iir_coeff_shadow.sv
// Five-entry shadow coefficient bank with address decode and sticky addr_err.
// o_bank_nxt exposes the bank including this beat's write.
module iir_coeff_shadow
  import iir_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_FRAC  = 18
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_we,
  input  logic                             i_clr,
  input  logic [2:0]                       i_addr,
  input  logic [COEFF_WIDTH-1:0]           i_data,
  output logic [NUM_COEFF*COEFF_WIDTH-1:0] o_bank_nxt,
  output logic                             o_addr_err
);

  localparam int BW = NUM_COEFF * COEFF_WIDTH;
  localparam logic [COEFF_WIDTH-1:0] UNITY =
    COEFF_WIDTH'(unity_coeff(COEFF_FRAC));
  localparam logic [BW-1:0] RST_BANK =
    {{(BW-COEFF_WIDTH){1'b0}}, UNITY};

  logic [BW-1:0] r_bank;
  logic [BW-1:0] w_bank_nxt;
  logic          r_addr_err;
  logic          w_addr_ok;

  assign w_addr_ok = (i_addr <= 3'(A2));

  always_comb begin
    w_bank_nxt = r_bank;
    if (i_we && w_addr_ok)
      w_bank_nxt[int'(i_addr)*COEFF_WIDTH +: COEFF_WIDTH] = i_data;
  end

  // A bad address on a commit beat still reports: set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank     <= RST_BANK;
      r_addr_err <= 1'b0;
    end else begin
      r_bank <= w_bank_nxt;
      if (i_we && !w_addr_ok)
        r_addr_err <= 1'b1;
      else if (i_clr)
        r_addr_err <= 1'b0;
    end
  end

  assign o_bank_nxt = w_bank_nxt;
  assign o_addr_err = r_addr_err;

endmodule

// File: rtl/iir_coeff_loader.sv
// Atomic IIR coefficient loader with readback verify and retry.
// Define IIR_CFG_BYPASS_HOLD_EN to add the bypass-hold phase.
module iir_coeff_loader
  import iir_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH  = 20,
  parameter int COEFF_FRAC   = 18,
  parameter int READBACK_LAT = 2,
  parameter int MAX_RETRY    = 2,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  iir_coeff_loader_if.slave                cfg,
  output logic                             coeff_wr_en,
  output logic [NUM_COEFF*COEFF_WIDTH-1:0] coeff_in,
  input  logic [NUM_COEFF*COEFF_WIDTH-1:0] coeff_out,
  output logic                             busy,
  output logic                             done,
  output logic                             load_err,
  output logic                             addr_err,
  output logic                             iir_bypass
);

  localparam int BW = NUM_COEFF * COEFF_WIDTH;
  localparam logic [COEFF_WIDTH-1:0] UNITY =
    COEFF_WIDTH'(unity_coeff(COEFF_FRAC));
  localparam logic [BW-1:0] RST_BANK =
    {{(BW-COEFF_WIDTH){1'b0}}, UNITY};
  // One down-counter serves both the readback wait and the hold
  localparam int CNT_MAX =
    (READBACK_LAT > HOLD_CYCLES) ? READBACK_LAT : HOLD_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  loader_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry;
  logic             r_ready;
  logic             r_wr_en;
  logic [BW-1:0]    r_coeff_in;
  logic             r_busy;
  logic             r_done;
  logic             r_load_err;
  logic             w_accept;
  logic             w_commit;
  logic [BW-1:0]    w_bank_nxt;

  assign w_accept = cfg.cfg_valid & r_ready;
  assign w_commit = w_accept & cfg.cfg_commit;

  iir_coeff_shadow #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFF_FRAC  (COEFF_FRAC)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_accept),
    .i_clr      (w_commit),
    .i_addr     (cfg.cfg_addr),
    .i_data     (cfg.cfg_data),
    .o_bank_nxt (w_bank_nxt),
    .o_addr_err (addr_err)
  );

`ifdef IIR_CFG_BYPASS_HOLD_EN
  logic r_bypass;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_ready    <= 1'b1;
      r_wr_en    <= 1'b0;
      r_coeff_in <= RST_BANK;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
`ifdef IIR_CFG_BYPASS_HOLD_EN
      r_bypass   <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Strobe and bus launch together so the IIR sees both in WRITE
          if (w_commit) begin
            r_state    <= WRITE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_en    <= 1'b1;
            r_coeff_in <= w_bank_nxt;
            r_load_err <= 1'b0;
`ifdef IIR_CFG_BYPASS_HOLD_EN
            r_bypass   <= 1'b1;
`endif
          end
        end
        WRITE: begin
          r_state <= WAIT;
          r_cnt   <= CNT_W'(READBACK_LAT);
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1))
            r_state <= CHECK;
        end
        CHECK: begin
          if (coeff_out == r_coeff_in) begin
            r_done  <= 1'b1;
            r_retry <= '0;
`ifdef IIR_CFG_BYPASS_HOLD_EN
            r_state <= HOLD;
            r_cnt   <= CNT_W'(HOLD_CYCLES);
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`endif
          end else if (r_retry < 3'(MAX_RETRY)) begin
            r_retry <= r_retry + 3'd1;
            r_state <= WRITE;
            r_wr_en <= 1'b1;
          end else begin
            r_load_err <= 1'b1;
            r_retry    <= '0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
          end
        end
`ifdef IIR_CFG_BYPASS_HOLD_EN
        HOLD: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_bypass <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign coeff_wr_en   = r_wr_en;
  assign coeff_in      = r_coeff_in;
  assign busy          = r_busy;
  assign done          = r_done;
  assign load_err      = r_load_err;
`ifdef IIR_CFG_BYPASS_HOLD_EN
  assign iir_bypass    = r_bypass;
`else
  assign iir_bypass    = 1'b0;
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader with an echoing IIR responder.
// Bypass expectations follow IIR_CFG_BYPASS_HOLD_EN when defined.
module tb_iir_coeff_loader;
  import iir_cfg_pkg::*;

  localparam int W    = 20;
  localparam int BW   = 5 * W;
  localparam int LAT  = 2;
  localparam int MR   = 2;
  localparam int HOLD = 16;

  localparam logic [BW-1:0] RST_BANK = {80'h0, 20'h40000};
  localparam logic [BW-1:0] BANK1 =
    {20'h1E000, 20'hC4000, 20'h1F000, 20'hC2000, 20'h1F000};
  localparam logic [BW-1:0] BANK2 =
    {20'h1E000, 20'h3A000, 20'h1F000, 20'hC2000, 20'h1F000};
  localparam logic [BW-1:0] BANK3 =
    {60'h0, 20'h00100, 20'h40000};

`ifdef IIR_CFG_BYPASS_HOLD_EN
  localparam int BYP_CYC  = 2 + LAT + HOLD;
  localparam int BYP_STUCK = 1;
`else
  localparam int BYP_CYC  = 0;
  localparam int BYP_STUCK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iir_coeff_loader_if #(.COEFF_WIDTH(W)) cfg ();

  logic          coeff_wr_en;
  logic [BW-1:0] coeff_in;
  logic [BW-1:0] coeff_out;
  logic          busy;
  logic          done;
  logic          load_err;
  logic          addr_err;
  logic          iir_bypass;

  iir_coeff_loader #(
    .COEFF_WIDTH  (W),
    .COEFF_FRAC   (18),
    .READBACK_LAT (LAT),
    .MAX_RETRY    (MR),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg),
    .coeff_wr_en (coeff_wr_en),
    .coeff_in    (coeff_in),
    .coeff_out   (coeff_out),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err),
    .addr_err    (addr_err),
    .iir_bypass  (iir_bypass)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int commit_edge = 0;
  int wr_cnt, wr_cyc, done_cnt, done_cyc, byp_cnt;
  int attempt = 0;
  int mode = 0;
  logic [BW-1:0] iir_q = '0;

  assign coeff_out = iir_q;

  function automatic logic [BW-1:0] corrupt(input int a, input int md);
    logic [BW-1:0] m;
    m = '0;
    if (md == 1 && a < 2) m[4*W] = 1'b1;
    if (md == 2) m[W+3] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (coeff_wr_en) begin
      iir_q <= coeff_in ^ corrupt(attempt, mode);
      attempt = attempt + 1;
    end

  always @(negedge clk) begin
    if (coeff_wr_en) begin
      wr_cnt++;
      if (wr_cyc < 0) wr_cyc = cyc + 1;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
    if (iir_bypass) byp_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    wr_cnt   = 0;
    wr_cyc   = -1;
    done_cnt = 0;
    done_cyc = -1;
    byp_cnt  = 0;
    attempt  = 0;
  endtask

  task automatic send(input logic [2:0] a,
                      input logic [W-1:0] d,
                      input logic c);
    int k;
    k = 0;
    while (!cfg.cfg_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cfg.cfg_ready) chk("ready_tmo", BW'(cfg.cfg_ready), 1);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_addr   = a;
    cfg.cfg_data   = d;
    cfg.cfg_commit = c;
    @(posedge clk);
    #1;
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_commit = 1'b0;
    if (c) commit_edge = cyc;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((busy || !cfg.cfg_ready) && k < 300);
    @(negedge clk);
    #1;
    chk("idle_tmo", BW'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_addr   = '0;
    cfg.cfg_data   = '0;
    cfg.cfg_commit = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_coeff", coeff_in, RST_BANK);
    chk("rst_ready", BW'(cfg.cfg_ready), 1);
    chk("rst_flags", BW'({busy, done, load_err, addr_err,
                          iir_bypass, coeff_wr_en}), 0);

    // Clean load
    clr_mon();
    send(3'd0, 20'h1F000, 1'b0);
    send(3'd1, 20'hC2000, 1'b0);
    send(3'd2, 20'h1F000, 1'b0);
    send(3'd3, 20'hC4000, 1'b0);
    send(3'd4, 20'h1E000, 1'b1);
    chk("busy_on", BW'({busy, cfg.cfg_ready}), 2'b10);
    wait_idle();
    chk("load1_wr_cnt", BW'(wr_cnt), 1);
    chk("load1_wr_cyc", BW'(wr_cyc), BW'(commit_edge + 1));
    chk("load1_done_cyc", BW'(done_cyc), BW'(commit_edge + 5));
    chk("load1_coeff", coeff_in, BANK1);
    chk("load1_err", BW'(load_err), 0);
    chk("load1_bypass_cyc", BW'(byp_cnt), BW'(BYP_CYC));

    // Two corrupted readbacks then a match
    mode = 1;
    clr_mon();
    send(3'd4, 20'h1E000, 1'b1);
    wait_idle();
    chk("retry_wr_cnt", BW'(wr_cnt), 3);
    chk("retry_done", BW'(done_cnt), 1);
    chk("retry_done_cyc", BW'(done_cyc), BW'(commit_edge + 13));
    chk("retry_err", BW'(load_err), 0);

    // Persistent corruption exhausts retries
    mode = 2;
    clr_mon();
    send(3'd4, 20'h1E000, 1'b1);
    wait_idle();
    chk("fail_wr_cnt", BW'(wr_cnt), 3);
    chk("fail_done", BW'(done_cnt), 0);
    chk("fail_err", BW'(load_err), 1);
    chk("fail_bypass", BW'(iir_bypass), BW'(BYP_STUCK));

    mode = 0;
    clr_mon();
    send(3'd4, 20'h1E000, 1'b1);
    chk("err_clr", BW'(load_err), 0);
    wait_idle();
    chk("recover_done", BW'(done_cnt), 1);
    chk("recover_bypass", BW'(iir_bypass), 0);

    // Illegal address, then write-plus-commit
    clr_mon();
    send(3'd6, 20'h12345, 1'b0);
    chk("addr_err_set", BW'(addr_err), 1);
    send(3'd3, 20'h3A000, 1'b1);
    chk("addr_err_clr", BW'(addr_err), 0);
    wait_idle();
    chk("wpc_coeff", coeff_in, BANK2);
    chk("wpc_done", BW'(done_cnt), 1);

    clr_mon();
    send(3'd7, 20'h12345, 1'b1);
    chk("addr_err_commit", BW'(addr_err), 1);
    wait_idle();
    chk("bad_addr_coeff", coeff_in, BANK2);

    // Reset during WAIT
    clr_mon();
    send(3'd1, 20'h00100, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_wait", BW'({busy, coeff_wr_en}), 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_coeff", coeff_in, RST_BANK);
    chk("mid_rst_flags", BW'({busy, done, load_err, addr_err,
                              iir_bypass, coeff_wr_en}), 0);
    chk("mid_rst_ready", BW'(cfg.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    send(3'd1, 20'h00100, 1'b1);
    wait_idle();
    chk("post_rst_coeff", coeff_in, BANK3);
    chk("post_rst_wr_cnt", BW'(wr_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Initiator side of the IIR coefficient-programming interface (coeff_wr_en / coeff_in[4:0] / coeff_out[4:0]).
- Accepts coefficient words from a config-bus handshake into a shadow bank, then writes all five to the notch IIR atomically in one cycle.
- Reads back coeff_out and reports load success or failure, retrying on mismatch.
- Sits between the register/config block and each IIR instance in the DFE filter chain.

Parameters:
- COEFF_WIDTH, 20, coefficient word width, signed Q2.18.
- COEFF_FRAC, 18, coefficient fractional bits; reset b0 = 2^COEFF_FRAC (1.0).
- READBACK_LAT, 2, cycles from the coeff_wr_en pulse until coeff_out is valid for compare (1..15).
- MAX_RETRY, 2, write retries after a readback mismatch before declaring error (0..7).
- HOLD_CYCLES, 16, bypass-hold length after a successful load (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  loader can accept a config word
- cfg_addr  in  3  coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- cfg_data  in  COEFF_WIDTH  signed coefficient value
- cfg_commit  in  1  request transfer of the shadow bank to the IIR; sampled with cfg_valid&cfg_ready
- coeff_wr_en  out  1  one-cycle write strobe to the IIR
- coeff_in  out  5xCOEFF_WIDTH  coefficient bus to the IIR, held stable outside loads
- coeff_out  in  5xCOEFF_WIDTH  IIR coefficient readback
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful load
- load_err  out  1  sticky; set on retry exhaustion, cleared by the next accepted commit
- addr_err  out  1  sticky; set on write with cfg_addr>4, cleared by the next accepted commit
- iir_bypass  out  1  bypass request to the IIR (optional feature only; otherwise tied 0)

Behaviour:
- Reset values:
  - Shadow bank and coeff_in: b0=2^COEFF_FRAC, all others 0.
  - coeff_wr_en=0, busy=0, done=0, load_err=0, addr_err=0, iir_bypass=0, cfg_ready=1, FSM=IDLE, retry_cnt=0.
- Handshake:
  - A word is accepted when cfg_valid&cfg_ready.
  - cfg_ready=1 only in IDLE; 0 in every other state.
- Shadow write: an accepted word with cfg_addr<=4 updates shadow[cfg_addr] next edge; cfg_addr 5..7 leaves the shadow unchanged and sets addr_err.
- Write plus commit in the same beat: the word is written first; the commit uses the updated bank.
- FSM states IDLE, WRITE, WAIT, CHECK, HOLD:
  - IDLE: accepted commit -> WRITE, busy=1.
  - WRITE: coeff_in<=shadow, coeff_wr_en=1 for exactly one cycle -> WAIT; the wait counter loads READBACK_LAT.
  - WAIT: decrement the counter; at 0 -> CHECK.
  - CHECK: compare all five coeff_out against coeff_in.
    - Match -> done pulse; go to HOLD (feature on) or IDLE (feature off); busy=0 on entering IDLE.
    - Mismatch with retry_cnt<MAX_RETRY -> retry_cnt++, go to WRITE.
    - Mismatch with retry_cnt=MAX_RETRY -> load_err=1, go to IDLE.
    - retry_cnt clears on leaving CHECK for IDLE/HOLD.
- Latency: commit accepted at edge N -> coeff_wr_en high during cycle N+1 -> compare in cycle N+2+READBACK_LAT -> done high in the following cycle.
- coeff_in changes only in WRITE. Shadow writes during a load are impossible, since cfg_ready=0.
- Reset mid-load aborts immediately: all outputs and shadow return to reset values; no partial coefficient write is ever presented.
- Comparisons are bitwise over full COEFF_WIDTH. There is no arithmetic; widths are pass-through.

Optional Feature:
- Macro IIR_CFG_BYPASS_HOLD_EN.
- Defined: iir_bypass=1 from the accepted-commit edge through all of WRITE/WAIT/CHECK, plus HOLD_CYCLES cycles in HOLD after a match, so the IIR output passes raw input while its state settles. On a load_err exit, iir_bypass stays 1 until the next successful load.
- Not defined: iir_bypass is constant 0, the HOLD state and its counter do not exist, and CHECK on a match goes directly to IDLE.

Decomposition:
- Shared package iir_cfg_pkg:
  - Enum coeff_idx_e (B0, B1, B2, A1, A2).
  - State enum loader_state_e.
  - Localparam NUM_COEFF=5.
  - Function unity_coeff(COEFF_FRAC) returning the reset b0 value.
  - Typedef coeff_bank_t (packed array of 5 signed COEFF_WIDTH words).
- One natural sub-module: iir_coeff_shadow, the 5-entry register bank with address decode and addr_err generation. The FSM, counters and compare stay in the top level.

Test Plan:
- After reset, no config -> coeff_in = {0x40000, 0, 0, 0, 0}, cfg_ready=1, all flags 0.
- Write b0=0x1F000, b1=0xC2000, b2=0x1F000, a1=0xC4000, a2=0x1E000, then commit; responder echoes after 2 cycles -> single coeff_wr_en, done at commit+5, coeff_in matches, busy low afterwards.
- Responder corrupts a2 readback on the first two attempts only, MAX_RETRY=2 -> three coeff_wr_en pulses, done asserted, load_err=0.
- Responder always corrupts b1 -> three pulses, load_err=1, no done; the next commit clears load_err.
- Write to cfg_addr=6 with data 0x12345, and a simultaneous write-plus-commit to addr 3 -> addr_err=1, shadow unchanged at index 6 aliases, and a1 is loaded with the new value in the same commit.
- rst_n low during WAIT, plus the feature build (IIR_CFG_BYPASS_HOLD_EN) -> outputs return to reset immediately; separately, confirm iir_bypass stays high for commit-through-CHECK plus 16 cycles.
